// File: rtl/nibble_serial_addsub.sv
// Multi-nibble add/subtract: a 4-bit ripple slice is reused once per clock,
// least-significant nibble first, with the carry/borrow held in a flop between nibbles.
module nibble_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // state | meaning
  // IDLE  | waiting for an operand set, in_ready = 1
  // CALC  | one nibble processed per cycle, LS nibble first
  // DONE  | result and flags held, out_valid = 1 until out_ready
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_r, b_r, s_q, s_next;
  logic             mode_r, carry_q, cout_q, ovf_q, zero_q;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic             last;
  logic [3:0]       na, nb, sum;
  logic             c, c_msb;

  assign last    = (idx_q == IW'(NIBBLES - 1));
  assign idx_nxt = last ? '0 : idx_q + 1'b1;

  // 4-bit ripple slice built from full-adder equations; c_msb is the carry into slice bit 3
  always_comb begin
    na     = a_r[idx_q*4 +: 4];
    nb     = b_r[idx_q*4 +: 4] ^ {4{mode_r}};
    sum    = '0;
    c      = carry_q;
    c_msb  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = na[i] ^ nb[i] ^ c;
      if (i == 3) c_msb = c;
      c = (na[i] & nb[i]) | (c & (na[i] ^ nb[i]));
    end
    s_next = s_q;
    s_next[idx_q*4 +: 4] = sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          mode_r  <= mode;
          carry_q <= mode;
          idx_q   <= '0;
        end
        CALC: begin
          s_q     <= s_next;
          carry_q <= c;
          idx_q   <= idx_nxt;
          if (last) begin
            cout_q <= c;
            ovf_q  <= c_msb ^ c;
            zero_q <= (s_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and back-to-back random checks of nibble_serial_addsub at WIDTH = 8.
module tb_nibble_serial_addsub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic       mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] s;
  logic       cout, ovf, zero;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: {zero, ovf, cout, s}
  function automatic logic [10:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic [8:0] r;
    logic       o;
    if (m) begin
      r = {1'b0, x} + {1'b0, ~y} + 9'd1;
      o = (x[7] != y[7]) && (r[7] != x[7]);
    end else begin
      r = {1'b0, x} + {1'b0, y};
      o = (x[7] == y[7]) && (r[7] != x[7]);
    end
    return {(r[7:0] == 8'h00), o, r[8], r[7:0]};
  endfunction

  // Presents one operand set, returns once out_valid is seen (#1 after that edge).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tm, output int lat);
    int n;
    in_valid = 1'b1; a = ta; b = tb; mode = tm;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       m;
    logic [7:0] s;
    logic       c, o, z;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'h80, 8'h02, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0},
    '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h03, 8'h04, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    int         lat, cyc, res_cnt, acc_cnt, last_acc;
    logic       acc;
    logic [10:0] exp_q;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_s", i), s, vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].o);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
      @(posedge clk); #1;
      chk($sformatf("v%0d_drop_valid", i), out_valid, 0);
      chk($sformatf("v%0d_idle", i), in_ready, 1);
    end

    // backpressure: 0x3C + 0x0F = 0x4B held in DONE
    out_ready = 1'b0;
    run_op(8'h3C, 8'h0F, 1'b0, lat);
    chk("bp_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a = 8'($urandom);
      b = 8'($urandom);
      mode = k[0];
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_s", s, 8'h4B);
      chk("bp_flags", {cout, ovf, zero}, 3'b000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_s_retained", s, 8'h4B);

    // reset after the first nibble of a CALC
    in_valid = 1'b1; a = 8'hAA; b = 8'h11; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_flags", {cout, ovf, zero}, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_valid", out_valid, 0);
    end
    run_op(8'h12, 8'h34, 1'b0, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_s", s, 8'h46);
    chk("post_rst_flags", {cout, ovf, zero}, 3'b000);
    @(posedge clk); #1;

    // back-to-back: 100 random pairs, alternating mode
    res_cnt = 0; acc_cnt = 0; last_acc = -1; cyc = 0; exp_q = '0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); mode = 1'b0;
    while (res_cnt < 100 && cyc < 600) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("b2b_s", s, exp_q[7:0]);
        chk("b2b_cout", cout, exp_q[8]);
        chk("b2b_ovf", ovf, exp_q[9]);
        chk("b2b_zero", zero, exp_q[10]);
        res_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (last_acc >= 0) chk("b2b_issue_gap", cyc - last_acc, 4);
        last_acc = cyc;
        exp_q = ref_op(a, b, mode);
        acc_cnt++;
        if (acc_cnt < 100) begin
          a = 8'($urandom);
          b = 8'($urandom);
          mode = acc_cnt[0];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", res_cnt, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
